// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// ---------------
// Round-robin scheduler that shares one UART transmitter between NREQ byte
// requesters. A winning request is latched into TX_P_DATA / TX_PAR_EN /
// TX_PAR_TYP, launched with a one-cycle TX_DATA_VALID, and owned until the
// transmitter's BUSY has risen and fallen again, or until BUSY fails to rise
// within BUSY_TO cycles. In that case the byte is dropped and TO_ERR is set.
//
// Handshake: requester i transfers a byte on any rising CLK edge where
// REQ_VALID[i] & REQ_READY[i] are both high. REQ_READY is combinational,
// one-hot or zero, and is only ever raised in IDLE while TX_BUSY is low.
// The requester must hold VALID and its data/config stable until READY.
//
// Ports
//   CLK, RST        clock (rising edge), asynchronous active-low reset
//   REQ_VALID       per-requester byte valid
//   REQ_DATA        requester i byte at [8i+7:8i]
//   REQ_PAR_EN      per-requester parity enable
//   REQ_PAR_TYP     per-requester parity type (0 even, 1 odd)
//   REQ_READY       one-hot accept to the round-robin winner
//   TX_P_DATA       latched byte to the transmitter
//   TX_DATA_VALID   single-cycle launch strobe, cycle after accept
//   TX_PAR_EN       latched parity enable
//   TX_PAR_TYP      latched parity type
//   TX_BUSY         transmitter busy
//   GRANT_ID        index of the current/last owner
//   ACTIVE          high while an arbiter-owned frame is in flight
//   CLR_ERR         synchronous clear of TO_ERR
//   TO_ERR          sticky BUSY-rise timeout flag
//   dbg_state       current FSM state (IDLE=0, ISSUE=1, WAIT_BUSY=2, WAIT_DONE=3)
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int BUSY_TO = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NREQ-1:0]     REQ_VALID,
    input  logic [8*NREQ-1:0]   REQ_DATA,
    input  logic [NREQ-1:0]     REQ_PAR_EN,
    input  logic [NREQ-1:0]     REQ_PAR_TYP,
    output logic [NREQ-1:0]     REQ_READY,
    output logic [7:0]          TX_P_DATA,
    output logic                TX_DATA_VALID,
    output logic                TX_PAR_EN,
    output logic                TX_PAR_TYP,
    input  logic                TX_BUSY,
    output logic [IDW-1:0]      GRANT_ID,
    output logic                ACTIVE,
    input  logic                CLR_ERR,
    output logic                TO_ERR,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;

    // Index of the last served requester; the search starts one above it.
    logic [IDW-1:0] rr_ptr;
    logic [3:0]     to_cnt;

    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] scan_idx;

    logic           accept;
    logic           release_frame;
    logic           timeout;

    assign dbg_state = state;

    // Round-robin winner: first valid requester at rr_ptr+1, rr_ptr+2, ...
    // wrapping modulo NREQ, so rr_ptr itself has the lowest priority.
    always_comb begin : winner_scan
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!win_found && REQ_VALID[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin : fsm_next
        state_nxt     = state;
        REQ_READY     = '0;
        accept        = 1'b0;
        release_frame = 1'b0;
        timeout       = 1'b0;
        case (state)
            IDLE: begin
                // A busy transmitter here belongs to someone else (or is a
                // stale frame after reset), so nobody is granted.
                if (win_found && !TX_BUSY) begin
                    REQ_READY = NREQ'(1) << win_idx;
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (TX_BUSY) begin
                    state_nxt = WAIT_DONE;
                end else if (to_cnt == 4'(BUSY_TO - 1)) begin
                    // This is the BUSY_TO-th cycle without BUSY: give up.
                    timeout       = 1'b1;
                    release_frame = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!TX_BUSY) begin
                    release_frame = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Launch data/config only move on an accept edge; the transmitter
    // computes parity combinationally from them for the whole frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            TX_P_DATA     <= '0;
            TX_PAR_EN     <= 1'b0;
            TX_PAR_TYP    <= 1'b0;
            TX_DATA_VALID <= 1'b0;
            GRANT_ID      <= '0;
            ACTIVE        <= 1'b0;
            rr_ptr        <= IDW'(NREQ - 1);
            to_cnt        <= '0;
            TO_ERR        <= 1'b0;
        end else begin
            TX_DATA_VALID <= accept;

            if (accept) begin
                TX_P_DATA  <= REQ_DATA[8*win_idx +: 8];
                TX_PAR_EN  <= REQ_PAR_EN[win_idx];
                TX_PAR_TYP <= REQ_PAR_TYP[win_idx];
                GRANT_ID   <= win_idx;
                ACTIVE     <= 1'b1;
            end

            if (release_frame) begin
                ACTIVE <= 1'b0;
                rr_ptr <= GRANT_ID;
            end

            if (state == ISSUE) begin
                to_cnt <= '0;
            end else if (state == WAIT_BUSY && !TX_BUSY) begin
                to_cnt <= to_cnt + 4'd1;
            end

            // A new timeout wins over a clear in the same cycle.
            if (timeout) begin
                TO_ERR <= 1'b1;
            end else if (CLR_ERR) begin
                TO_ERR <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. Requesters are modelled as per-requester
// FIFOs that keep VALID high while they hold bytes; a transmitter model
// answers launches with BUSY. Expected launches come from a queue-level
// round-robin model and are checked by a monitor whenever DATA_VALID fires.
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int BUSY_TO = 4;
    localparam int W       = 8 + 1 + 1 + IDW;
    localparam int DEPTH   = 128;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_par_en;
    logic [NREQ-1:0]   req_par_typ;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        tx_p_data;
    logic              tx_data_valid;
    logic              tx_par_en;
    logic              tx_par_typ;
    logic              tx_busy;
    logic [IDW-1:0]    grant_id;
    logic              active;
    logic              clr_err;
    logic              to_err;
    logic [1:0]        dbg_state;

    uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .BUSY_TO(BUSY_TO)) dut (
        .CLK(clk), .RST(rst_n),
        .REQ_VALID(req_valid), .REQ_DATA(req_data),
        .REQ_PAR_EN(req_par_en), .REQ_PAR_TYP(req_par_typ),
        .REQ_READY(req_ready),
        .TX_P_DATA(tx_p_data), .TX_DATA_VALID(tx_data_valid),
        .TX_PAR_EN(tx_par_en), .TX_PAR_TYP(tx_par_typ),
        .TX_BUSY(tx_busy),
        .GRANT_ID(grant_id), .ACTIVE(active),
        .CLR_ERR(clr_err), .TO_ERR(to_err),
        .dbg_state(dbg_state)
    );

    // ---------------- bench state ----------------
    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    logic [7:0] fifo_data [NREQ][DEPTH];
    logic       fifo_pe   [NREQ][DEPTH];
    logic       fifo_pt   [NREQ][DEPTH];
    int         head [NREQ];
    int         tail [NREQ];

    logic [NREQ-1:0] hs_seen = '0;
    int  model_last = NREQ - 1;

    logic tx_busy_model = 1'b0;
    logic busy_force    = 1'b0;
    int   tx_mode       = 0;    // 0: answer launches, 1: never raise BUSY
    int   fix_delay     = -1;   // <0: random BUSY rise delay
    int   fix_len       = 0;    // 0: random BUSY length

    assign tx_busy = tx_busy_model | busy_force;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic load(input int r, input logic [7:0] d, input logic pe, input logic pt);
        fifo_data[r][tail[r]] = d;
        fifo_pe[r][tail[r]]   = pe;
        fifo_pt[r][tail[r]]   = pt;
        tail[r]++;
    endtask

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < NREQ; i++) if (head[i] != tail[i]) e = 1'b0;
        return e;
    endfunction

    // Reference model: every pending requester stays valid, so each
    // arbitration serves the next non-empty FIFO after the last one served.
    function automatic void plan_batch();
        int pos[NREQ];
        int left;
        int r;
        left = 0;
        for (int i = 0; i < NREQ; i++) begin
            pos[i] = head[i];
            left += tail[i] - head[i];
        end
        while (left > 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                r = (model_last + k) % NREQ;
                if (pos[r] < tail[r]) begin
                    exp_q.push_back({IDW'(r), fifo_pt[r][pos[r]], fifo_pe[r][pos[r]],
                                     fifo_data[r][pos[r]]});
                    pos[r]++;
                    left--;
                    model_last = r;
                    break;
                end
            end
        end
    endfunction

    task automatic drain(input int budget);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = (exp_q.size() == 0) && !active && !tx_busy && all_empty();
        end
        check("drain_bound", done, 1);
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_ready"}, req_ready, 0);
        check({tag, "_pdata"}, tx_p_data, 0);
        check({tag, "_dv"}, tx_data_valid, 0);
        check({tag, "_par_en"}, tx_par_en, 0);
        check({tag, "_par_typ"}, tx_par_typ, 0);
        check({tag, "_grant"}, grant_id, 0);
        check({tag, "_active"}, active, 0);
        check({tag, "_to_err"}, to_err, 0);
    endtask

    task automatic wait_dv(input string name, input int budget);
        int n;
        n = 0;
        while (!tx_data_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, tx_data_valid, 1);
    endtask

    // ---------------- requester driver ----------------
    initial begin : req_driver
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        req_valid   = '0;
        req_data    = '0;
        req_par_en  = '0;
        req_par_typ = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (hs_seen[i]) head[i]++;
                if (head[i] < tail[i]) begin
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = fifo_data[i][head[i]];
                    req_par_en[i]       = fifo_pe[i][head[i]];
                    req_par_typ[i]      = fifo_pt[i][head[i]];
                end else begin
                    req_valid[i]        = 1'b0;
                    req_data[8*i +: 8]  = 8'h00;
                    req_par_en[i]       = 1'b0;
                    req_par_typ[i]      = 1'b0;
                end
            end
        end
    end

    // ---------------- transmitter model ----------------
    initial begin : tx_model
        int d;
        int len;
        forever begin
            @(negedge clk);
            if (rst_n && tx_data_valid && tx_mode == 0) begin
                d   = (fix_delay >= 0) ? fix_delay : $urandom_range(0, 2);
                len = (fix_len > 0) ? fix_len : $urandom_range(1, 6);
                @(posedge clk);
                #1;
                repeat (d) begin
                    @(posedge clk);
                    #1;
                end
                tx_busy_model = 1'b1;
                repeat (len) @(posedge clk);
                #1;
                tx_busy_model = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [W-1:0] got;
        logic [W-1:0] exp;
        logic [W-1:0] cur;
        logic         prev_hs;
        cur     = '0;
        prev_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hs_seen = '0;
                prev_hs = 1'b0;
                cur     = '0;
            end else begin
                got = {grant_id, tx_par_typ, tx_par_en, tx_p_data};
                check("launch_latency", tx_data_valid, prev_hs);
                if (tx_data_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_launch", got, 32'hFFFF_FFFF);
                    end else begin
                        exp = exp_q.pop_front();
                        check("launch_frame", got, exp);
                    end
                    cur = got;
                end else begin
                    check("output_hold", got, cur);
                end
                check("ready_onehot",
                      ((req_ready & (req_ready - 1'b1)) != '0) ||
                      ((req_ready & ~req_valid) != '0), 0);
                hs_seen = req_valid & req_ready;
                prev_hs = |(req_valid & req_ready);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #500000;
        errors++;
        $display("FAIL watchdog expired at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin : test
        int n;
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        outputs_zero("reset");
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Fairness: all four valid with two bytes each, long BUSY.
        fix_len   = 11;
        fix_delay = 0;
        @(negedge clk);
        for (int r = 0; r < NREQ; r++) begin
            load(r, 8'(8'h10 * (r + 1)), r[0], r[1]);
            load(r, 8'(8'h10 * (r + 1)), r[0], r[1]);
        end
        plan_batch();
        drain(600);
        fix_len   = 0;
        fix_delay = -1;

        // Pointer wrap: after a grant to 3, requesters 0 and 3 compete.
        @(negedge clk);
        load(3, 8'h3C, 1'b1, 1'b0);
        plan_batch();
        drain(200);
        @(negedge clk);
        load(0, 8'h0A, 1'b0, 1'b1);
        load(3, 8'h3D, 1'b1, 1'b1);
        plan_batch();
        drain(200);

        // Single byte on requester 2.
        @(negedge clk);
        load(2, 8'hA5, 1'b1, 1'b1);
        plan_batch();
        n = 0;
        while (req_ready == '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("single_ready", req_ready, 4'b0100);
        @(negedge clk);
        check("single_dv", tx_data_valid, 1);
        @(negedge clk);
        check("single_dv_once", tx_data_valid, 0);
        drain(200);
        check("idle_hold_data", tx_p_data, 8'hA5);
        check("idle_hold_grant", grant_id, 2);

        // Foreign BUSY blocks the grant until it falls.
        busy_force = 1'b1;
        @(negedge clk);
        load(1, 8'h5B, 1'b0, 1'b0);
        plan_batch();
        repeat (5) begin
            @(negedge clk);
            check("blocked_ready", req_ready, 0);
        end
        @(posedge clk);
        #1 busy_force = 1'b0;
        @(negedge clk);
        check("unblock_ready", req_ready, 4'b0010);
        drain(200);

        // BUSY never rises: timeout after BUSY_TO cycles in WAIT_BUSY.
        tx_mode = 1;
        @(negedge clk);
        load(1, 8'hC3, 1'b1, 1'b0);
        plan_batch();
        wait_dv("to_launch", 10);
        repeat (BUSY_TO) @(negedge clk);
        check("to_err_early", to_err, 0);
        check("to_active_early", active, 1);
        @(negedge clk);
        check("to_err_set", to_err, 1);
        check("to_active_clear", active, 0);
        tx_mode = 0;
        load(3, 8'h7E, 1'b0, 1'b1);
        plan_batch();
        drain(200);
        check("to_err_sticky", to_err, 1);
        @(posedge clk);
        #1 clr_err = 1'b1;
        @(negedge clk);
        check("clr_not_early", to_err, 1);
        @(posedge clk);
        #1 clr_err = 1'b0;
        @(negedge clk);
        check("to_err_cleared", to_err, 0);

        // Randomized batches.
        for (int round = 0; round < 6; round++) begin
            @(negedge clk);
            for (int r = 0; r < NREQ; r++) begin
                n = $urandom_range(0, 3);
                repeat (n) load(r, 8'($urandom_range(0, 255)),
                                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            plan_batch();
            drain(800);
        end

        // Asynchronous reset in WAIT_DONE.
        fix_len   = 11;
        fix_delay = 0;
        @(negedge clk);
        load(2, 8'h99, 1'b1, 1'b1);
        plan_batch();
        wait_dv("rst_launch", 10);
        @(negedge clk);
        @(negedge clk);
        check("rst_active_before", active, 1);
        #2 rst_n = 1'b0;
        #1;
        outputs_zero("async_reset");
        check("rst_exp_empty", exp_q.size(), 0);
        model_last = NREQ - 1;
        fix_len    = 0;
        fix_delay  = -1;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        load(3, 8'h33, 1'b0, 1'b0);
        load(0, 8'h00, 1'b1, 1'b0);
        plan_batch();
        drain(300);
        check("final_grant", grant_id, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter between NREQ byte requesters.
- Each requester presents a byte plus per-frame parity configuration over a valid/ready handshake.
- The arbiter latches the winner, issues a single-cycle DATA_VALID to the transmitter and holds data/config stable for the whole frame; it then waits for BUSY to rise and fall before re-arbitrating.
- It sits between the client logic and the transmitter top (P_DATA / DATA_VALID / PAR_EN / PAR_TYP / BUSY).

Parameters:
- NREQ, 4: number of requesters (2..8).
- IDW, 2: width of GRANT_ID; must be at least ceil(log2(NREQ)).
- BUSY_TO, 4: maximum cycles to wait for TX_BUSY to rise after DATA_VALID before flagging an error (1..15).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- REQ_VALID  in  NREQ  per-requester byte valid; the requester holds it with stable data until its READY.
- REQ_DATA  in  8*NREQ  bytes; requester i occupies bits [8i+7:8i].
- REQ_PAR_EN  in  NREQ  per-requester parity enable.
- REQ_PAR_TYP  in  NREQ  per-requester parity type (0 even, 1 odd).
- REQ_READY  out  NREQ  one-hot accept; transfer happens when VALID&READY in the same cycle.
- TX_P_DATA  out  8  byte to the transmitter.
- TX_DATA_VALID  out  1  single-cycle launch strobe.
- TX_PAR_EN  out  1  latched parity enable.
- TX_PAR_TYP  out  1  latched parity type.
- TX_BUSY  in  1  transmitter busy.
- GRANT_ID  out  IDW  index of the current/last owner.
- ACTIVE  out  1  high while a frame owned by the arbiter is in flight.
- CLR_ERR  in  1  synchronous clear of TO_ERR.
- TO_ERR  out  1  sticky BUSY timeout flag.

Behaviour:
- Reset (RST=0, async):
  - State=IDLE.
  - All outputs 0: REQ_READY, TX_P_DATA, TX_DATA_VALID, TX_PAR_EN, TX_PAR_TYP, GRANT_ID, ACTIVE, TO_ERR.
  - Round-robin pointer=NREQ-1, so requester 0 has first priority.
  - Reset mid-frame abandons the frame; the requester is not re-acknowledged.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - REQ_READY is combinational: one-hot to the winner only when some REQ_VALID=1 and TX_BUSY=0. Otherwise REQ_READY=0.
  - Winner = first set REQ_VALID bit searching from pointer+1 upward, wrapping modulo NREQ.
  - On the accept edge:
    - latch REQ_DATA/PAR_EN/PAR_TYP of the winner into TX_P_DATA/TX_PAR_EN/TX_PAR_TYP;
    - GRANT_ID=winner; ACTIVE=1; go to ISSUE.
  - TX_BUSY=1 in IDLE (foreign or stale frame) blocks all grants.
- ISSUE:
  - TX_DATA_VALID=1 for exactly this one cycle, which is the cycle after accept (launch latency = 1 cycle).
  - Clear timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - TX_BUSY=1 -> WAIT_DONE.
  - Otherwise increment counter. When the counter reaches BUSY_TO:
    - set TO_ERR; ACTIVE=0; pointer=GRANT_ID; go to IDLE. The byte is dropped.
- WAIT_DONE:
  - When TX_BUSY=0: ACTIVE=0, pointer=GRANT_ID, go to IDLE.
  - Re-arbitration is possible in the cycle after BUSY falls; the next TX_DATA_VALID comes no earlier than 2 cycles after BUSY falls.
- Stability: TX_P_DATA, TX_PAR_EN and TX_PAR_TYP change only on an accept edge.
  - They hold through the whole frame, because transmitter parity is computed combinationally from P_DATA.
  - They keep the last value while idle.
- REQ_VALID dropping before READY is a protocol violation; the arbiter simply re-evaluates each IDLE cycle, with no latched request.
- Only the granted requester sees READY. Other requesters keep VALID asserted and are served in rotation: no requester waits more than NREQ-1 frames.
- TO_ERR: set has priority over CLR_ERR in the same cycle; otherwise CLR_ERR=1 clears it on the next edge.
- Single clock domain, no internal buffering beyond one held byte.

Test Plan:
- Single byte: REQ_VALID[2]=1, REQ_DATA byte2=8'hA5, PAR_EN=1, PAR_TYP=1, TX_BUSY low.
  -> REQ_READY=4'b0100 in cycle 0; TX_DATA_VALID=1 in cycle 1 only; TX_P_DATA=8'hA5, TX_PAR_EN=1, TX_PAR_TYP=1 held until BUSY falls; GRANT_ID=2.
- Fairness: all four VALID held continuously with bytes 8'h10/8'h20/8'h30/8'h40; model BUSY high 11 cycles per frame.
  -> grant order 0,1,2,3,0; each byte appears once per rotation.
- Pointer wrap: after a grant to 3, assert VALID on 0 and 3.
  -> 0 wins; then 3.
- Blocking: TX_BUSY forced high in IDLE with VALID[1]=1.
  -> REQ_READY stays 0 until BUSY=0; grant follows in that same cycle.
- Timeout: BUSY_TO=4; TX_BUSY never rises after launch.
  -> TO_ERR=1 four cycles after WAIT_BUSY entry; ACTIVE=0; next request is served; CLR_ERR pulse -> TO_ERR=0 the next cycle.
- Async reset in WAIT_DONE: assert RST low mid-frame.
  -> all outputs 0 immediately; after release, requester 0 wins over requester 3 when both are valid.
